md5_pad: RTL and testbench



---
 rtl/md5_pad.sv | 207 ++++++++++++++++++++
 tb/tb_md5_pad.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_pad.sv
`default_nettype none
// ============================================================================
//  Module   : md5_pad
//  Purpose  : Byte-serial MD5 message padder and 512-bit block assembler.
//             Accepts message bytes over a valid/ready handshake, appends the
//             0x80 marker, zero fill and the 64-bit little-endian bit length,
//             and hands complete blocks to the MD5 update stage one at a time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    single clock, rising edge
//    rst_n      in   1    asynchronous reset, active low
//    in_valid   in   1    in_data / in_last / in_zero valid
//    in_ready   out  1    padder accepts a byte this cycle (registered)
//    in_data    in   8    message byte
//    in_last    in   1    beat ends the message
//    in_zero    in   1    with in_last: beat carries no byte
//    blk_valid  out  1    blk_data holds a complete block
//    blk_ready  in   1    downstream accepts the block
//    blk_data   out  512  block; byte n at [8n+7:8n], word k at [32k+31:32k]
//    blk_first  out  1    first block of a message
//    blk_last   out  1    final block of a message
// ============================================================================
module md5_pad (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_zero,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_OUT   = 2'd1,
    ST_EXTRA = 2'd2
  } state_t;

  state_t         state_q,      state_d;
  logic [5:0]     idx_q,        idx_d;
  logic [60:0]    cnt_q,        cnt_d;
  logic [511:0]   blk_q,        blk_d;
  logic           in_ready_q,   in_ready_d;
  logic           blk_valid_q,  blk_valid_d;
  logic           blk_first_q,  blk_first_d;
  logic           blk_last_q,   blk_last_d;
  // A second padding block is owed after the current one is accepted.
  logic           extra_pend_q, extra_pend_d;
  // The owed block starts with the 0x80 marker (message filled a whole block).
  logic           extra_mark_q, extra_mark_d;
  // The next block to be emitted opens a new message.
  logic           first_pend_q, first_pend_d;

  logic           accept;
  logic           byte_inc;
  logic [60:0]    cnt_inc;
  logic [6:0]     fill_n;

  // in_ready is registered and only ever high in FILL, so it alone qualifies
  // a byte transfer.
  assign accept   = in_valid & in_ready_q;
  // in_zero only suppresses the byte on a last beat; otherwise it is ignored.
  assign byte_inc = ~(in_last & in_zero);
  assign cnt_inc  = cnt_q + {60'd0, byte_inc};
  // Bytes in the block once this beat lands (0..64).
  assign fill_n   = {1'b0, idx_q} + {6'd0, byte_inc};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    extra_pend_d = extra_pend_q;
    extra_mark_d = extra_mark_q;
    first_pend_d = first_pend_q;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (byte_inc) begin
            blk_d[{idx_q, 3'b000} +: 8] = in_data;
          end
          cnt_d = cnt_inc;

          if (!in_last) begin
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd63) begin
              // Full data block mid-message.
              state_d      = ST_OUT;
              blk_first_d  = first_pend_q;
              first_pend_d = 1'b0;
              blk_last_d   = 1'b0;
            end
          end else begin
            state_d      = ST_OUT;
            blk_first_d  = first_pend_q;
            first_pend_d = 1'b0;
            idx_d        = 6'd0;
            // The buffer is cleared whenever a block leaves, so every slot
            // not written here is already zero.
            if (fill_n <= 7'd55) begin
              blk_d[{fill_n[5:0], 3'b000} +: 8] = 8'h80;
              blk_d[511:448] = {cnt_inc, 3'b000};
              blk_last_d     = 1'b1;
            end else if (fill_n <= 7'd63) begin
              // Marker fits but the length does not.
              blk_d[{fill_n[5:0], 3'b000} +: 8] = 8'h80;
              blk_last_d   = 1'b0;
              extra_pend_d = 1'b1;
              extra_mark_d = 1'b0;
            end else begin
              // Data filled the block; marker moves to the extra block.
              blk_last_d   = 1'b0;
              extra_pend_d = 1'b1;
              extra_mark_d = 1'b1;
            end
          end
        end
      end

      ST_OUT: begin
        if (blk_ready) begin
          blk_d       = '0;
          blk_first_d = 1'b0;
          blk_last_d  = 1'b0;
          if (extra_pend_q) begin
            state_d = ST_EXTRA;
          end else begin
            state_d = ST_FILL;
            if (blk_last_q) begin
              // Message complete: next block starts a fresh message.
              cnt_d        = '0;
              idx_d        = 6'd0;
              first_pend_d = 1'b1;
            end
          end
        end
      end

      ST_EXTRA: begin
        blk_d = '0;
        if (extra_mark_q) begin
          blk_d[7:0] = 8'h80;
        end
        blk_d[511:448] = {cnt_q, 3'b000};
        state_d        = ST_OUT;
        blk_first_d    = 1'b0;
        blk_last_d     = 1'b1;
        extra_pend_d   = 1'b0;
        extra_mark_d   = 1'b0;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Handshake flags follow the next state so they change on the same edge
    // that moves the FSM.
    in_ready_d  = (state_d == ST_FILL);
    blk_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      idx_q        <= 6'd0;
      cnt_q        <= '0;
      blk_q        <= '0;
      in_ready_q   <= 1'b0;
      blk_valid_q  <= 1'b0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      extra_pend_q <= 1'b0;
      extra_mark_q <= 1'b0;
      first_pend_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      in_ready_q   <= in_ready_d;
      blk_valid_q  <= blk_valid_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
      extra_pend_q <= extra_pend_d;
      extra_mark_q <= extra_mark_d;
      first_pend_q <= first_pend_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_md5_pad.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md5_pad
//  Purpose  : Self-checking bench for md5_pad. A reference padder builds the
//             expected blocks of each message and queues them; a monitor pops
//             and compares every block the DUT hands over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md5_pad;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_zero;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  md5_pad dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_zero   (in_zero),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    int len;
    int pat;
    bit zero_end;
    int exp_blocks;
  } vec_t;

  blk_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  int           rx_count = 0;
  logic [511:0] last_rx = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int i);
    case (pat)
      0:       return 8'h41;
      1:       return 8'(8'h61 + i);
      2:       return 8'(8'h62 + i);
      default: return 8'(i * 13 + 5);
    endcase
  endfunction

  // Reference padding: lay out the whole padded message, then slice it.
  task automatic model_push(input int len, input int pat);
    logic [7:0]  mem [0:255];
    logic [63:0] bitlen;
    blk_t        b;
    int          padded;
    int          nb;
    padded = ((len + 8) / 64 + 1) * 64;
    nb     = padded / 64;
    bitlen = 64'(len) * 64'd8;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < len; i++) mem[i] = pat_byte(pat, i);
    mem[len] = 8'h80;
    for (int j = 0; j < 8; j++) mem[padded - 8 + j] = bitlen[8*j +: 8];
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int m = 0; m < 64; m++) b.data[8*m +: 8] = mem[64*k + m];
      b.first = (k == 0);
      b.last  = (k == nb - 1);
      sb.push_back(b);
    end
  endtask

  // Drive one beat and hold it until the DUT takes it (bounded).
  task automatic drive_beat(input logic [7:0] d, input logic l, input logic z);
    int   n;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_zero  = z;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got in_ready=0 after %0d cycles expected 1", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_zero  = 1'b0;
  endtask

  // Send a message; unterminated messages queue no expectation.
  task automatic send_msg(input int len, input int pat, input bit zero_end, input bit terminate);
    logic z;
    logic l;
    if (terminate) model_push(len, pat);
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      l = terminate && !zero_end && (i == len - 1);
      // in_zero on a non-last beat must be ignored.
      z = (pat == 3) && (i % 5 == 2) && !l;
      drive_beat(pat_byte(pat, i), l, z);
    end
    if (terminate && zero_end) drive_beat(8'hAA, 1'b1, 1'b1);
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || blk_valid) && n < 2000);
    if (sb.size() != 0 || blk_valid) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d blocks pending expected 0", sb.size());
    end
  endtask

  // Monitor: compare accepted blocks and check stability under backpressure.
  logic         hold_q = 1'b0;
  logic [511:0] hold_data;
  logic         hold_first;
  logic         hold_last;

  always @(negedge clk) begin
    blk_t e;
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", {511'd0, blk_valid}, 512'd1);
        chk("hold_data",  blk_data, hold_data);
        chk("hold_first", {511'd0, blk_first}, {511'd0, hold_first});
        chk("hold_last",  {511'd0, blk_last},  {511'd0, hold_last});
      end
      if (blk_valid && blk_ready) begin
        rx_count++;
        last_rx = blk_data;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_block: got %0h expected none", blk_data);
        end else begin
          e = sb.pop_front();
          chk("blk_data",  blk_data, e.data);
          chk("blk_first", {511'd0, blk_first}, {511'd0, e.first});
          chk("blk_last",  {511'd0, blk_last},  {511'd0, e.last});
        end
      end
      hold_q     = blk_valid && !blk_ready;
      hold_data  = blk_data;
      hold_first = blk_first;
      hold_last  = blk_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_abc_block;
    chk("abc_word0",  {480'd0, last_rx[31:0]},   {480'd0, 32'h80636261});
    chk("abc_length", {448'd0, last_rx[511:448]}, {448'd0, 64'h18});
    chk("abc_zeros",  {96'd0, last_rx[447:32]},  512'd0);
  endtask

  vec_t vecs[11];
  int   rx0;

  initial begin
    vecs[0]  = '{len: 3,   pat: 1, zero_end: 1'b0, exp_blocks: 1};
    vecs[1]  = '{len: 0,   pat: 3, zero_end: 1'b1, exp_blocks: 1};
    vecs[2]  = '{len: 55,  pat: 0, zero_end: 1'b0, exp_blocks: 1};
    vecs[3]  = '{len: 56,  pat: 0, zero_end: 1'b0, exp_blocks: 2};
    vecs[4]  = '{len: 63,  pat: 3, zero_end: 1'b0, exp_blocks: 2};
    vecs[5]  = '{len: 64,  pat: 3, zero_end: 1'b0, exp_blocks: 2};
    vecs[6]  = '{len: 65,  pat: 3, zero_end: 1'b0, exp_blocks: 2};
    vecs[7]  = '{len: 64,  pat: 3, zero_end: 1'b1, exp_blocks: 2};
    vecs[8]  = '{len: 3,   pat: 3, zero_end: 1'b1, exp_blocks: 1};
    vecs[9]  = '{len: 120, pat: 3, zero_end: 1'b0, exp_blocks: 3};
    vecs[10] = '{len: 119, pat: 3, zero_end: 1'b0, exp_blocks: 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_zero   = 1'b0;
    blk_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {511'd0, in_ready},  512'd0);
    chk("rst_blk_valid", {511'd0, blk_valid}, 512'd0);
    chk("rst_blk_data",  blk_data, 512'd0);
    chk("rst_blk_first", {511'd0, blk_first}, 512'd0);
    chk("rst_blk_last",  {511'd0, blk_last},  512'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_pre_edge", {511'd0, in_ready}, 512'd0);
    @(posedge clk);
    #1;
    chk("in_ready_rise", {511'd0, in_ready}, 512'd1);

    // Table-driven messages.
    for (int i = 0; i < 11; i++) begin
      rx0 = rx_count;
      send_msg(vecs[i].len, vecs[i].pat, vecs[i].zero_end, 1'b1);
      wait_drain();
      chk($sformatf("blocks_len%0d", vecs[i].len), 512'(rx_count - rx0), 512'(vecs[i].exp_blocks));
    end

    // 64 bytes: data block, one bubble cycle, then the padding block.
    send_msg(64, 3, 1'b0, 1'b1);
    @(negedge clk);
    chk("bubble_v0", {510'd0, blk_valid, blk_last}, {510'd0, 2'b10});
    @(negedge clk);
    chk("bubble_gap", {511'd0, blk_valid}, 512'd0);
    @(negedge clk);
    chk("bubble_v1", {510'd0, blk_valid, blk_last}, {510'd0, 2'b11});
    wait_drain();

    // Backpressure on "abc".
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    send_msg(3, 1, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  {511'd0, in_ready},  512'd0);
      chk("bp_blk_valid", {511'd0, blk_valid}, 512'd1);
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    wait_drain();
    chk_abc_block();

    // Back-to-back "a" then "b".
    rx0 = rx_count;
    send_msg(1, 1, 1'b0, 1'b1);
    send_msg(1, 2, 1'b0, 1'b1);
    wait_drain();
    chk("b2b_blocks", 512'(rx_count - rx0), 512'd2);

    // Reset in the middle of a message discards it.
    rx0 = rx_count;
    send_msg(30, 3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {511'd0, in_ready},  512'd0);
    chk("midrst_blk_valid", {511'd0, blk_valid}, 512'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_msg(3, 1, 1'b0, 1'b1);
    wait_drain();
    chk("midrst_blocks", 512'(rx_count - rx0), 512'd1);
    chk_abc_block();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
